alu_seq: RTL
============

Name: alu_seq

Overview:
- Multi-byte operation sequencer that acts as the issuing side of the 8-bit ALU interface.
- Accepts one wide operation request and drives alu_cmd, inA, inB and sc_i one byte per cycle to the combinational ALU.
- Captures rslt and sc_o each cycle, chains carry/shift bits between bytes, and assembles the wide result plus flags.
- Sits between the control unit and the byte ALU for wide arithmetic, shift and logic instructions.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand (must be >=2); wide width W = 8*NBYTES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  request strobe; sampled only in IDLE
op  input  4  ALU command for the wide operation (same encoding as alu_cmd)
a_in  input  W  operand A, captured on accepted start
b_in  input  W  operand B, captured on accepted start
cin  input  1  initial carry/shift-in bit, captured on accepted start
busy  output  1  high while a request is in progress (RUN or DONE)
done  output  1  one-cycle pulse on completion
error  output  1  one-cycle pulse with done when op is unsupported
result  output  W  assembled result, held until the next accepted start
cout  output  1  final carry/shift-out bit
zero  output  1  high when result == 0
pari  output  1  XOR reduction of result
alu_cmd  output  4  command to the byte ALU
alu_inA  output  8  byte of A
alu_inB  output  8  byte of B
alu_sc_i  output  1  carry/shift-in to the byte ALU
alu_rslt  input  8  byte result from the ALU
alu_sc_o  input  1  carry/shift-out from the ALU

Behaviour:
- Reset (async, rst_n=0): state IDLE; result=0, cout=0, zero=1, pari=0, busy=0, done=0, error=0; operand registers and byte index cleared.
- Reset mid-operation aborts the request immediately. No done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE: alu_cmd=4'b1111, alu_inA=0, alu_inB=0, alu_sc_i=0.
  - start=1 with a supported op: latch op/a_in/b_in/cin, clear result, go to RUN, busy=1 from the next cycle.
  - start=1 with an unsupported op (4'b1000-4'b1110): go to DONE, result=0, cout=0, error pulses together with done.
- Supported ops: 0000 ADD, 0111 ADDI (identical to ADD), 0001 LSH, 0010 RSH, 0011 MOV, 0100 OR, 0101 XOR, 0110 AND, 1111 NOP (identical to MOV).
- RUN lasts exactly NBYTES cycles; byte index k issues one byte per cycle.
  - ALU is combinational, so alu_rslt/alu_sc_o are sampled on the same edge that advances k.
- Byte order:
  - RSH: k = NBYTES-1 down to 0.
  - All other ops: k = 0 up to NBYTES-1.
- Carry chain:
  - ADD/ADDI/LSH/RSH: alu_sc_i = latched cin on the first issued byte, then alu_sc_o captured from the previous byte.
  - Other ops: alu_sc_i=0.
- alu_inA = A byte k, alu_inB = B byte k, alu_cmd = latched op throughout RUN.
- Each RUN edge writes alu_rslt into result byte k.
- Last RUN edge sets cout:
  - chained ops: captured alu_sc_o;
  - other ops: 0.
- Then go to DONE.
- DONE (1 cycle): done=1, busy=1, zero/pari computed from the final result. Next state IDLE.
- Latency: accepted start to done = NBYTES+1 cycles; error path = 1 cycle.
- start while busy is ignored and not queued. start in the same cycle that DONE returns to IDLE is also ignored; start is sampled only when the state is IDLE.
- zero/pari are computed locally from the assembled result. ALU flag outputs are not used.
- Outputs result/cout/zero/pari are stable from done until the next accepted start.
- During RUN, partially written result values are not meaningful.

Test Plan:
- NBYTES=4, ADD a=0x00FFFFFF b=0x00000001 cin=0 -> done at start+5; result 0x01000000, cout=0, zero=0, pari=1, error=0.
- ADD a=0xFFFFFFFF b=0x00000001 cin=0 -> result 0x00000000, cout=1, zero=1, pari=0; alu_sc_i observed 0,1,1,1 across RUN cycles.
- LSH a=0x80000001 cin=1 -> result 0x00000003, cout=1. RSH a=0x00000101 cin=1 -> result 0x80000080, cout=1, bytes issued in order 3,2,1,0.
- XOR a=0xF0F0F0F0 b=0xFFFF0000 -> result 0x0F0FF0F0, cout=0, pari=0. MOV a=0x12345678 -> result 0x12345678.
- op=4'b1010 start -> done and error both high on the next cycle only; result=0, no RUN cycles; busy high for 1 cycle.
- Second start pulsed during RUN -> ignored; first result unchanged. rst_n low during RUN byte 2 -> all outputs at reset values immediately, no done. A new request after reset completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// Wide-operand sequencer driving an 8-bit combinational ALU one byte per cycle.
// Latency: accepted start to done = NBYTES+1 cycles; unsupported op = 1 cycle.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) while busy.
module alu_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic                  pari,
  output logic [3:0]            alu_cmd,
  output logic [7:0]            alu_inA,
  output logic [7:0]            alu_inB,
  output logic                  alu_sc_i,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_o
);

  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LSH  = 4'b0001;
  localparam logic [3:0] OP_RSH  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Supported commands: every code with the MSB clear, plus NOP.
  function automatic logic op_supported(input logic [3:0] o);
    return (o[3] == 1'b0) || (o == OP_NOP);
  endfunction

  // Commands whose carry/shift bit ripples from one byte into the next.
  function automatic logic op_chained(input logic [3:0] o);
    return (o == OP_ADD) || (o == OP_ADDI) || (o == OP_LSH) || (o == OP_RSH);
  endfunction

  state_t                   state_q, state_d;
  logic [3:0]               op_q, op_d;
  logic [NBYTES-1:0][7:0]   a_q, a_d;
  logic [NBYTES-1:0][7:0]   b_q, b_d;
  logic [NBYTES-1:0][7:0]   result_q, result_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            cnt_q, cnt_d;
  logic                     sc_q, sc_d;
  logic                     cout_q, cout_d;
  logic                     err_q, err_d;

  // Next-state logic: accept requests in IDLE, walk the bytes in RUN, pulse in DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    sc_d     = sc_q;
    cout_d   = cout_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          result_d = '0;
          cout_d   = 1'b0;
          if (op_supported(op)) begin
            op_d    = op;
            a_d     = a_in;
            b_d     = b_in;
            sc_d    = cin;
            cnt_d   = '0;
            k_d     = (op == OP_RSH) ? K_LAST : '0;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_RUN: begin
        // The ALU is combinational, so this edge captures the byte issued this cycle.
        result_d[k_q] = alu_rslt;
        sc_d          = alu_sc_o;
        cnt_d         = cnt_q + K_ONE;
        k_d           = (op_q == OP_RSH) ? (k_q - K_ONE) : (k_q + K_ONE);
        if (cnt_q == K_LAST) begin
          cout_d  = op_chained(op_q) ? alu_sc_o : 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 4'b0000;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      sc_q     <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      sc_q     <= sc_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  // Byte ALU drive: idle pattern outside RUN, selected operand bytes during RUN.
  always_comb begin
    alu_cmd  = 4'b1111;
    alu_inA  = 8'h00;
    alu_inB  = 8'h00;
    alu_sc_i = 1'b0;
    if (state_q == S_RUN) begin
      alu_cmd  = op_q;
      alu_inA  = a_q[k_q];
      alu_inB  = b_q[k_q];
      alu_sc_i = op_chained(op_q) ? sc_q : 1'b0;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign error  = done & err_q;
  assign result = result_q;
  assign cout   = cout_q;
  // Flags follow the held result, so they stay valid until the next accepted start.
  assign zero   = ~|result_q;
  assign pari   = ^result_q;

endmodule
